crossbar_output_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for one crossbar output port. Selects one of
//  NUM_IN input ports, holds the grant for a packet (up to MAX_BURST beats), and

---
 rtl/crossbar_output_arbiter.sv | 117 +++++++++++
 tb/tb_crossbar_output_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_output_arbiter.sv
// Round-robin arbiter and beat sequencer for one crossbar output port.
// Holds a grant for one packet (at most MAX_BURST beats) and registers the
// selected beat toward the output port register.
module crossbar_output_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned SEL_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int unsigned CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        last,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic [SEL_W-1:0]         sel,
  output logic                     valid_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     busy
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  cur_beat;
  logic               cur_req;
  logic               cur_last;
  logic               acc;
  logic               drop_grant;
  logic [SEL_W-1:0]   rr_next;

  // Circular search for the first requester starting at rr_ptr.
  always_comb begin
    logic [SEL_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = SEL_W'((32'(rr_ptr) + k) % NUM_IN);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Mux the granted input's request, last flag and beat using the registered select.
  always_comb begin
    cur_beat = '0;
    cur_req  = 1'b0;
    cur_last = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        cur_beat = data_in[i*DATA_W +: DATA_W];
        cur_req  = req[i];
        cur_last = last[i];
      end
    end
  end

  // Beat transfer, release decision and the pointer value that follows the granted input.
  always_comb begin
    acc        = (state == StBusy) && cur_req && out_ready;
    // A withdrawn request releases without a beat; otherwise release on the final beat.
    drop_grant = (state == StBusy) &&
                 (!cur_req || (acc && (cur_last || burst_cnt == CNT_W'(MAX_BURST - 1))));
    rr_next    = (sel == SEL_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;
  end

  // Arbitration FSM with registered grant, select and output beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      grant     <= '0;
      sel       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          valid_out <= 1'b0;
          if (pick_found) begin
            grant     <= NUM_IN'(1) << pick_idx;
            sel       <= pick_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= StBusy;
          end
        end
        StBusy: begin
          valid_out <= acc;
          if (acc) begin
            data_out  <= cur_beat;
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (drop_grant) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= rr_next;
            state  <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_output_arbiter.sv
// Self-checking bench for crossbar_output_arbiter: per-input packet queues feed
// the DUT and a transaction-level model predicts grant, select and beats.
module tb_crossbar_output_arbiter;

  localparam int NUM_IN    = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN-1:0]        last;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     out_ready;
  logic [NUM_IN-1:0]        grant;
  logic [1:0]               sel;
  logic                     valid_out;
  logic [DATA_W-1:0]        data_out;
  logic                     busy;

  crossbar_output_arbiter #(
    .NUM_IN   (NUM_IN),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .last     (last),
    .data_in  (data_in),
    .out_ready(out_ready),
    .grant    (grant),
    .sel      (sel),
    .valid_out(valid_out),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pending beats per input: bit DATA_W is the end-of-packet flag.
  logic [DATA_W:0] q [NUM_IN][$];
  bit              wd [NUM_IN];
  logic            rdy;

  // Reference model: who holds the output, where the search starts, beats in this grant.
  bit          m_busy;
  int          m_sel, m_rr, m_cnt;
  logic [3:0]  exp_grant;
  logic        exp_valid;
  logic [7:0]  exp_data;

  logic [15:0] obs, expv;
  int          n_checks, n_pass;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_rr = 0; m_cnt = 0;
    exp_grant = '0; exp_valid = 1'b0; exp_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      q[i].delete();
      wd[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; last = '0; data_in = '0; out_ready = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one cycle from the queues, advance the model, sample DUT after the edge.
  task automatic step();
    logic [NUM_IN-1:0] r;
    bit acc, lst, found;
    int g;
    for (int i = 0; i < NUM_IN; i++) begin
      r[i] = (q[i].size() > 0) && !wd[i];
      if (q[i].size() > 0) begin
        data_in[i*DATA_W +: DATA_W] = q[i][0][DATA_W-1:0];
        last[i] = q[i][0][DATA_W];
      end else begin
        data_in[i*DATA_W +: DATA_W] = 8'($urandom);
        last[i] = 1'($urandom);
      end
    end
    req = r;
    out_ready = rdy;
    exp_valid = 1'b0;
    if (m_busy) begin
      g = m_sel;
      acc = r[g] && rdy;
      lst = 0;
      if (acc) begin
        exp_data = q[g][0][DATA_W-1:0];
        lst = q[g][0][DATA_W];
        void'(q[g].pop_front());
        m_cnt++;
        exp_valid = 1'b1;
      end
      if (!r[g] || (acc && (lst || m_cnt == MAX_BURST))) begin
        m_busy = 0;
        exp_grant = '0;
        m_rr = (g + 1) % NUM_IN;
      end
    end else if (r != 0) begin
      found = 0;
      for (int k = 0; k < NUM_IN; k++) begin
        int c;
        c = (m_rr + k) % NUM_IN;
        if (!found && r[c]) begin
          found = 1;
          m_sel = c;
        end
      end
      m_busy = 1;
      m_cnt = 0;
      exp_grant = 4'(1) << m_sel;
    end
    @(posedge clk); #1;
    obs  = {grant, sel, valid_out, busy, data_out};
    expv = {exp_grant, 2'(m_sel), exp_valid, m_busy, exp_data};
    for (int i = 0; i < NUM_IN; i++) begin
      if (wd[i]) begin
        q[i].delete();
        wd[i] = 0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, sel, valid_out, busy, data_out} !== 16'h0)
      $display("FAIL reset_init: got %h want 0000", {grant, sel, valid_out, busy, data_out});
    else n_pass++;
    q[1].push_back({1'b0, 8'h5A});
    q[1].push_back({1'b0, 8'h6B});
    q[1].push_back({1'b1, 8'h7C});
    step();
    step();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, sel, valid_out, busy, data_out} !== 16'h0)
      $display("FAIL reset_async: got %h want 0000", {grant, sel, valid_out, busy, data_out});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (valid_out !== 1'b0 || grant !== 4'b0)
        $display("FAIL reset_abort: got v=%b g=%b want v=0 g=0000", valid_out, grant);
      else n_pass++;
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] want[3];
    want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC;
    do_reset();
    q[1].push_back({1'b0, 8'hAA});
    q[1].push_back({1'b0, 8'hBB});
    q[1].push_back({1'b1, 8'hCC});
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (obs !== expv) $display("FAIL single_model c%0d: got %h want %h", c, obs, expv);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL single_grant: got %b want 0010", grant);
        else n_pass++;
      end else begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== want[c-2])
          $display("FAIL single_beat c%0d: got v=%b d=%h want v=1 d=%h",
                   c, valid_out, data_out, want[c-2]);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (grant !== 4'b0) $display("FAIL single_release: got %b want 0000", grant);
        else n_pass++;
      end
    end
    // Search now starts at input 2.
    for (int i = 0; i < NUM_IN; i++) q[i].push_back({1'b1, 8'(8'hE0 + i)});
    step();
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL single_rrptr: got %b want 0100", grant);
    else n_pass++;
  endtask

  task automatic test_all_request();
    logic [3:0] gexp[10];
    gexp = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    do_reset();
    for (int i = 0; i < NUM_IN; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
    q[0].push_back({1'b1, 8'h50});
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (obs !== expv) $display("FAIL allreq_model c%0d: got %h want %h", c, obs, expv);
      else n_pass++;
      n_checks++;
      if (grant !== gexp[c]) $display("FAIL allreq_order c%0d: got %b want %b", c, grant, gexp[c]);
      else n_pass++;
    end
  endtask

  task automatic test_burst_limit();
    logic [3:0] gexp[9];
    logic       vexp[9];
    gexp = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    vexp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int b = 0; b < 6; b++) q[2].push_back({1'b0, 8'(8'h20 + b)});
    for (int c = 0; c < 9; c++) begin
      step();
      n_checks++;
      if (obs !== expv) $display("FAIL burst_model c%0d: got %h want %h", c, obs, expv);
      else n_pass++;
      n_checks++;
      if (grant !== gexp[c] || valid_out !== vexp[c])
        $display("FAIL burst_seq c%0d: got g=%b v=%b want g=%b v=%b",
                 c, grant, valid_out, gexp[c], vexp[c]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    q[0].push_back({1'b0, 8'h30});
    q[0].push_back({1'b0, 8'h31});
    q[0].push_back({1'b1, 8'h32});
    for (int c = 1; c <= 7; c++) begin
      rdy = !(c >= 3 && c <= 5);
      step();
      n_checks++;
      if (obs !== expv) $display("FAIL bp_model c%0d: got %h want %h", c, obs, expv);
      else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_checks++;
        if (valid_out !== 1'b0 || grant !== 4'b0001 || data_out !== 8'h30)
          $display("FAIL bp_stall c%0d: got v=%b g=%b d=%h want v=0 g=0001 d=30",
                   c, valid_out, grant, data_out);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h31)
          $display("FAIL bp_resume: got v=%b d=%h want v=1 d=31", valid_out, data_out);
        else n_pass++;
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int b = 0; b < 4; b++) q[3].push_back({1'b0, 8'(8'h40 + b)});
    step();
    step();
    wd[3] = 1;
    step();
    n_checks++;
    if (grant !== 4'b0 || valid_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL withdraw_drop: got g=%b v=%b b=%b want g=0000 v=0 b=0",
               grant, valid_out, busy);
    else n_pass++;
    for (int i = 0; i < NUM_IN; i++) q[i].push_back({1'b1, 8'(8'hF0 + i)});
    step();
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL withdraw_rrptr: got %b want 0001", grant);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (q[i].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          bit term;
          len  = $urandom_range(1, 6);
          term = ($urandom_range(4) != 0);
          for (int b = 0; b < len; b++)
            q[i].push_back({term && (b == len - 1), 8'($urandom)});
        end
      end
      if ($urandom_range(49) == 0) wd[$urandom_range(NUM_IN - 1)] = 1;
      rdy = ($urandom_range(3) != 0);
      step();
      n_checks++;
      if (obs !== expv) $display("FAIL random_model c%0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single_packet();
    test_all_request();
    test_burst_limit();
    test_backpressure();
    test_withdraw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
